// File: rtl/pcm_multi_voice_if.sv
// pcm_multi_voice_if
//   Bundles the CPU register bus, the sample-ROM port and the audio outputs of
//   pcm_multi_voice. CLK and RES stay plain ports on the module.
//
//   CPU side : CE (sample tick), CS (1-cycle write strobe), AB {voice, reg}, DB.
//   ROM side : ROM_ADDR, ROM_REQ out; ROM_ACK, ROM_DATA in.
//   Outputs  : ACTIVE (per-voice playing flags), MIX (summed mono output).
//   Debug    : dbg_busy (arbiter has a request outstanding), dbg_pending.
//
//   ROM handshake: ROM_REQ rises with ROM_ADDR valid, and both are held
//   unchanged until the first cycle with ROM_ACK=1. That cycle carries
//   ROM_DATA and completes the transfer. ROM_REQ is low in the following cycle.
//   ROM_ACK is ignored whenever no request is outstanding.
//
//   master: the CPU/ROM/mixer environment. slave: the PCM engine.
interface pcm_multi_voice_if #(
    parameter int NCH = 4,
    parameter int AW  = 17
);
    localparam int ABW = 3 + $clog2(NCH);
    localparam int MW  = 11 + $clog2(NCH);

    logic           CE;
    logic           CS;
    logic [ABW-1:0] AB;
    logic [7:0]     DB;
    logic [AW-1:0]  ROM_ADDR;
    logic           ROM_REQ;
    logic           ROM_ACK;
    logic [7:0]     ROM_DATA;
    logic [NCH-1:0] ACTIVE;
    logic [MW-1:0]  MIX;
    logic           dbg_busy;
    logic [NCH-1:0] dbg_pending;

    modport master (
        output CE, CS, AB, DB, ROM_ACK, ROM_DATA,
        input  ROM_ADDR, ROM_REQ, ACTIVE, MIX, dbg_busy, dbg_pending
    );

    modport slave (
        input  CE, CS, AB, DB, ROM_ACK, ROM_DATA,
        output ROM_ADDR, ROM_REQ, ACTIVE, MIX, dbg_busy, dbg_pending
    );
endinterface

// File: rtl/pcm_multi_voice.sv
// pcm_multi_voice
//   NCH-voice 7-bit PCM sample player. Each voice has a pitch prescaler, a
//   sample address, a 4-bit volume and a loop flag. All voices share one
//   sample-ROM port through a round-robin arbiter. MIX is the registered sum of
//   sample*volume over all voices.
//
//   Ports: CLK, RES (synchronous, active-high), bus (pcm_multi_voice_if.slave).
//   The register map is 8 registers per voice, addressed by AB = {voice, reg}.
module pcm_multi_voice #(
    parameter int NCH = 4,
    parameter int AW  = 17,
    parameter int PW  = 12
) (
    input  logic             CLK,
    input  logic             RES,
    pcm_multi_voice_if.slave bus
);
    localparam int VW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int MW = 11 + $clog2(NCH);

    typedef enum logic {S_IDLE, S_REQ} arb_state_t;

    logic [PW-1:0]  pitch_q  [NCH];
    logic [PW-1:0]  pitch_d  [NCH];
    logic [AW-1:0]  start_q  [NCH];
    logic [AW-1:0]  start_d  [NCH];
    logic [3:0]     vol_q    [NCH];
    logic [3:0]     vol_d    [NCH];
    logic [PW-1:0]  cnt_q    [NCH];
    logic [PW-1:0]  cnt_d    [NCH];
    logic [AW-1:0]  addr_q   [NCH];
    logic [AW-1:0]  addr_d   [NCH];
    logic [6:0]     sample_q [NCH];
    logic [6:0]     sample_d [NCH];
    logic [NCH-1:0] loop_q, loop_d;
    logic [NCH-1:0] active_q, active_d;
    logic [NCH-1:0] pending_q, pending_d;
    arb_state_t     state_q, state_d;
    logic [VW-1:0]  gnt_q, gnt_d;
    logic [VW-1:0]  rr_q, rr_d;
    logic           stale_q, stale_d;
    logic           req_q, req_d;
    logic [AW-1:0]  rom_addr_q, rom_addr_d;
    logic [MW-1:0]  mix_q, mix_d;

    // Combinational scratch
    logic [NCH-1:0] chg;        // voice address/state changed this cycle
    logic [2:0]     wr_reg;
    int             wr_voice;
    logic [31:0]    p_ext, s_ext;
    logic           key_on, key_off, advance, own_ack, ack_ok, found;
    logic [VW-1:0]  pick;
    int             idx;

    always_comb begin
        pitch_d    = pitch_q;
        start_d    = start_q;
        vol_d      = vol_q;
        cnt_d      = cnt_q;
        addr_d     = addr_q;
        sample_d   = sample_q;
        loop_d     = loop_q;
        active_d   = active_q;
        pending_d  = pending_q;
        state_d    = state_q;
        gnt_d      = gnt_q;
        rr_d       = rr_q;
        stale_d    = stale_q;
        req_d      = req_q;
        rom_addr_d = rom_addr_q;
        chg        = '0;
        p_ext      = '0;
        s_ext      = '0;
        key_on     = 1'b0;
        key_off    = 1'b0;
        advance    = 1'b0;
        own_ack    = 1'b0;
        found      = 1'b0;
        pick       = '0;
        idx        = 0;
        wr_reg     = bus.AB[2:0];
        wr_voice   = int'(bus.AB >> 3);
        ack_ok     = (state_q == S_REQ) && bus.ROM_ACK;

        for (int v = 0; v < NCH; v++) begin
            key_on  = bus.CS && (wr_voice == v) && (wr_reg == 3'd6);
            key_off = bus.CS && (wr_voice == v) && (wr_reg == 3'd7);
            own_ack = ack_ok && (int'(gnt_q) == v);
            advance = 1'b0;

            // Register writes: the upper byte registers zero-fill any field
            // bits above the byte they carry.
            if (bus.CS && (wr_voice == v)) begin
                p_ext = 32'(pitch_q[v]);
                s_ext = 32'(start_q[v]);
                case (wr_reg)
                    3'd0: p_ext[7:0]   = bus.DB;
                    3'd1: p_ext[31:8]  = 24'(bus.DB);
                    3'd2: s_ext[7:0]   = bus.DB;
                    3'd3: s_ext[15:8]  = bus.DB;
                    3'd4: s_ext[31:16] = 16'(bus.DB);
                    3'd5: begin
                        loop_d[v] = bus.DB[0];
                        vol_d[v]  = bus.DB[7:4];
                    end
                    default: ;
                endcase
                pitch_d[v] = PW'(p_ext);
                start_d[v] = AW'(s_ext);
            end

            if (bus.CE && active_q[v]) begin
                if (cnt_q[v] == {PW{1'b1}}) begin
                    cnt_d[v]     = pitch_q[v];
                    addr_d[v]    = addr_q[v] + AW'(1);
                    pending_d[v] = 1'b1;
                    advance      = 1'b1;
                end else begin
                    cnt_d[v] = cnt_q[v] + PW'(1);
                end
            end

            // A stale fetch (address moved or key event while outstanding)
            // leaves pending as the event set it and drops the data.
            if (own_ack && !key_on && !key_off) begin
                if (!advance && !stale_q) pending_d[v] = 1'b0;
                if (!stale_q && active_q[v]) begin
                    if (bus.ROM_DATA[7]) begin
                        if (loop_q[v]) begin
                            addr_d[v]    = start_q[v];
                            cnt_d[v]     = pitch_q[v];
                            pending_d[v] = 1'b1;
                        end else begin
                            active_d[v]  = 1'b0;
                            sample_d[v]  = '0;
                            pending_d[v] = 1'b0;
                        end
                    end else begin
                        sample_d[v] = bus.ROM_DATA[6:0];
                    end
                end
            end

            // Key events override prescaler and end-marker outcomes.
            if (key_on) begin
                addr_d[v]    = start_q[v];
                cnt_d[v]     = pitch_q[v];
                active_d[v]  = 1'b1;
                pending_d[v] = 1'b1;
            end else if (key_off) begin
                active_d[v]  = 1'b0;
                sample_d[v]  = '0;
                pending_d[v] = 1'b0;
            end

            chg[v] = advance | key_on | key_off;
        end

        // Round-robin search starting at rr_q.
        for (int k = 0; k < NCH; k++) begin
            idx = (int'(rr_q) + k) % NCH;
            if (!found && pending_q[idx]) begin
                found = 1'b1;
                pick  = VW'(idx);
            end
        end

        case (state_q)
            S_IDLE: begin
                if (found) begin
                    state_d    = S_REQ;
                    gnt_d      = pick;
                    req_d      = 1'b1;
                    rom_addr_d = addr_q[pick];
                    // Address sampled this cycle may already be superseded.
                    stale_d    = chg[pick];
                end
            end
            S_REQ: begin
                if (bus.ROM_ACK) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    stale_d = 1'b0;
                    rr_d    = (int'(gnt_q) == NCH - 1) ? '0 : gnt_q + VW'(1);
                end else if (chg[gnt_q]) begin
                    stale_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        mix_d = '0;
        for (int v = 0; v < NCH; v++) begin
            mix_d = mix_d + MW'(sample_q[v]) * MW'(vol_q[v]);
        end
    end

    always_ff @(posedge CLK) begin
        if (RES) begin
            for (int v = 0; v < NCH; v++) begin
                pitch_q[v]  <= '0;
                start_q[v]  <= '0;
                vol_q[v]    <= '0;
                cnt_q[v]    <= '0;
                addr_q[v]   <= '0;
                sample_q[v] <= '0;
            end
            loop_q     <= '0;
            active_q   <= '0;
            pending_q  <= '0;
            state_q    <= S_IDLE;
            gnt_q      <= '0;
            rr_q       <= '0;
            stale_q    <= 1'b0;
            req_q      <= 1'b0;
            rom_addr_q <= '0;
            mix_q      <= '0;
        end else begin
            pitch_q    <= pitch_d;
            start_q    <= start_d;
            vol_q      <= vol_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            sample_q   <= sample_d;
            loop_q     <= loop_d;
            active_q   <= active_d;
            pending_q  <= pending_d;
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            rr_q       <= rr_d;
            stale_q    <= stale_d;
            req_q      <= req_d;
            rom_addr_q <= rom_addr_d;
            mix_q      <= mix_d;
        end
    end

    assign bus.ROM_ADDR    = rom_addr_q;
    assign bus.ROM_REQ     = req_q;
    assign bus.ACTIVE      = active_q;
    assign bus.MIX         = mix_q;
    assign bus.dbg_busy    = (state_q == S_REQ);
    assign bus.dbg_pending = pending_q;
endmodule
